// File: rtl/syndrome_arbiter.sv
// Round-robin sharing of one syndrome unit between two requesters. An owner-tag
// pipeline that matches the unit's latency returns each syndrome to the requester that issued it.
module syndrome_arbiter #(
   parameter int MAX_CODEWORD_WIDTH = 32,
   parameter int MAX_PARITY_WIDTH   = 6,
   parameter int LATENCY            = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req0_valid,
   output logic                          req0_ready,
   input  logic [MAX_CODEWORD_WIDTH-1:0] req0_data,
   input  logic [1:0]                    req0_mod,
   input  logic                          req1_valid,
   output logic                          req1_ready,
   input  logic [MAX_CODEWORD_WIDTH-1:0] req1_data,
   input  logic [1:0]                    req1_mod,
   output logic [MAX_CODEWORD_WIDTH-1:0] mult_data,
   output logic [1:0]                    mult_mod,
   input  logic [MAX_PARITY_WIDTH-1:0]   mult_syndrome,
   output logic                          rsp0_valid,
   output logic [MAX_PARITY_WIDTH-1:0]   rsp0_syndrome,
   output logic                          rsp0_err,
   output logic                          rsp1_valid,
   output logic [MAX_PARITY_WIDTH-1:0]   rsp1_syndrome,
   output logic                          rsp1_err,
   output logic                          busy
);

   localparam logic [1:0] MOD_ILLEGAL = 2'b11;

   logic                          last_q, last_d;
   logic                          gnt0, gnt1, issue, issue_err;
   logic [MAX_CODEWORD_WIDTH-1:0] issue_data;
   logic [1:0]                    issue_mod;
   logic [MAX_CODEWORD_WIDTH-1:0] mult_data_q, mult_data_d;
   logic [1:0]                    mult_mod_q, mult_mod_d;
   logic [LATENCY:0]              tag_vld_q, tag_own_q, tag_err_q;
   logic                          retire, retire_own, retire_err;
   logic [MAX_PARITY_WIDTH-1:0]   retire_syn;
   logic                          rsp0_valid_q, rsp1_valid_q;
   logic                          rsp0_err_q, rsp1_err_q;
   logic [MAX_PARITY_WIDTH-1:0]   rsp0_syn_q, rsp1_syn_q;

   // Round-robin grant; last_q=1 means requester 1 won the previous transfer
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end else if (req0_valid && req1_valid) begin
         gnt0 = last_q;
         gnt1 = ~last_q;
      end else begin
         gnt0 = req0_valid;
         gnt1 = req1_valid;
      end
   end

   // Issue-stage mux and next-state for the pointer and unit operands
   always_comb begin
      issue      = gnt0 | gnt1;
      issue_data = gnt1 ? req1_data : req0_data;
      issue_mod  = gnt1 ? req1_mod  : req0_mod;
      issue_err  = issue && (issue_mod == MOD_ILLEGAL);
      if (issue) begin
         last_d      = gnt1;
         mult_data_d = issue_err ? {MAX_CODEWORD_WIDTH{1'b0}} : issue_data;
         mult_mod_d  = issue_mod;
      end else begin
         last_d      = last_q;
         mult_data_d = mult_data_q;
         mult_mod_d  = mult_mod_q;
      end
   end

   // Retiring tag selects the owner and masks the unit result for illegal requests
   always_comb begin
      retire     = tag_vld_q[LATENCY];
      retire_own = tag_own_q[LATENCY];
      retire_err = tag_err_q[LATENCY];
      if (retire_err) begin
         retire_syn = {MAX_PARITY_WIDTH{1'b0}};
      end else begin
         retire_syn = mult_syndrome;
      end
   end

   // Pointer, issue registers, tag pipeline and response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q       <= 1'b1;
         mult_data_q  <= {MAX_CODEWORD_WIDTH{1'b0}};
         mult_mod_q   <= 2'b00;
         tag_vld_q    <= {(LATENCY+1){1'b0}};
         tag_own_q    <= {(LATENCY+1){1'b0}};
         tag_err_q    <= {(LATENCY+1){1'b0}};
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_err_q   <= 1'b0;
         rsp1_err_q   <= 1'b0;
         rsp0_syn_q   <= {MAX_PARITY_WIDTH{1'b0}};
         rsp1_syn_q   <= {MAX_PARITY_WIDTH{1'b0}};
      end else begin
         last_q       <= last_d;
         mult_data_q  <= mult_data_d;
         mult_mod_q   <= mult_mod_d;
         tag_vld_q    <= {tag_vld_q[LATENCY-1:0], issue};
         tag_own_q    <= {tag_own_q[LATENCY-1:0], gnt1};
         tag_err_q    <= {tag_err_q[LATENCY-1:0], issue_err};
         rsp0_valid_q <= retire & ~retire_own;
         rsp1_valid_q <= retire & retire_own;
         if (retire && !retire_own) begin
            rsp0_syn_q <= retire_syn;
            rsp0_err_q <= retire_err;
         end
         if (retire && retire_own) begin
            rsp1_syn_q <= retire_syn;
            rsp1_err_q <= retire_err;
         end
      end
   end

   assign req0_ready    = gnt0;
   assign req1_ready    = gnt1;
   assign mult_data     = mult_data_q;
   assign mult_mod      = mult_mod_q;
   assign rsp0_valid    = rsp0_valid_q;
   assign rsp1_valid    = rsp1_valid_q;
   assign rsp0_syndrome = rsp0_syn_q;
   assign rsp1_syndrome = rsp1_syn_q;
   assign rsp0_err      = rsp0_err_q;
   assign rsp1_err      = rsp1_err_q;
   assign busy          = (|tag_vld_q) | rsp0_valid_q | rsp1_valid_q;

endmodule

// File: tb/tb_syndrome_arbiter.sv
// Bench for syndrome_arbiter: directed and random traffic against a queue-based
// reference model; a second instance checks the LATENCY=5 build.
module tb_syndrome_arbiter;

   localparam int LAT  = 2;
   localparam int LAT5 = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_data, req1_data;
   logic [1:0]  req0_mod, req1_mod;

   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy;
   logic [31:0] mult_data;
   logic [1:0]  mult_mod;
   logic [5:0]  mult_syndrome, rsp0_syndrome, rsp1_syndrome;

   logic        req0_ready_5, req1_ready_5, rsp0_valid_5, rsp1_valid_5, rsp0_err_5, rsp1_err_5, busy_5;
   logic [31:0] mult_data_5;
   logic [1:0]  mult_mod_5;
   logic [5:0]  mult_syndrome_5, rsp0_syndrome_5, rsp1_syndrome_5;

   always #5 clk = ~clk;

   syndrome_arbiter #(.MAX_CODEWORD_WIDTH(32), .MAX_PARITY_WIDTH(6), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_mod(req0_mod),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_mod(req1_mod),
      .mult_data(mult_data), .mult_mod(mult_mod), .mult_syndrome(mult_syndrome),
      .rsp0_valid(rsp0_valid), .rsp0_syndrome(rsp0_syndrome), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_syndrome(rsp1_syndrome), .rsp1_err(rsp1_err),
      .busy(busy)
   );

   syndrome_arbiter #(.MAX_CODEWORD_WIDTH(32), .MAX_PARITY_WIDTH(6), .LATENCY(LAT5)) u_dut5 (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready_5), .req0_data(req0_data), .req0_mod(req0_mod),
      .req1_valid(req1_valid), .req1_ready(req1_ready_5), .req1_data(req1_data), .req1_mod(req1_mod),
      .mult_data(mult_data_5), .mult_mod(mult_mod_5), .mult_syndrome(mult_syndrome_5),
      .rsp0_valid(rsp0_valid_5), .rsp0_syndrome(rsp0_syndrome_5), .rsp0_err(rsp0_err_5),
      .rsp1_valid(rsp1_valid_5), .rsp1_syndrome(rsp1_syndrome_5), .rsp1_err(rsp1_err_5),
      .busy(busy_5)
   );

   // Syndrome unit models: data[5:0] ^ {4'b0, mod}, LAT register stages
   logic [5:0] su_pipe  [LAT];
   logic [5:0] su_pipe5 [LAT5];
   always @(posedge clk) begin
      su_pipe[0] <= mult_data[5:0] ^ {4'b0000, mult_mod};
      for (int i = 1; i < LAT; i++) su_pipe[i] <= su_pipe[i-1];
      su_pipe5[0] <= mult_data_5[5:0] ^ {4'b0000, mult_mod_5};
      for (int k = 1; k < LAT5; k++) su_pipe5[k] <= su_pipe5[k-1];
   end
   assign mult_syndrome   = su_pipe[LAT-1];
   assign mult_syndrome_5 = su_pipe5[LAT5-1];

   typedef struct {
      int         due;
      bit         own;
      logic [5:0] syn;
      bit         err;
   } exp_t;

   exp_t        q[$];
   int          glog[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   bit          m_last;
   logic [5:0]  m_hold0, m_hold1;
   logic [31:0] m_md;
   logic [1:0]  m_mm;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_last  = 1'b1;
      m_hold0 = 6'h00;
      m_hold1 = 6'h00;
      m_md    = 32'h0;
      m_mm    = 2'b00;
   endtask

   // One clock cycle: drive, check grant, cross the edge, check outputs
   task automatic step(input bit v0, input logic [31:0] d0, input logic [1:0] m0,
                       input bit v1, input logic [31:0] d1, input logic [1:0] m1);
      bit          g0, g1, ev0, ev1, ee0, ee1;
      exp_t        e;
      logic [1:0]  mod;
      logic [31:0] data;
      req0_valid = v0; req0_data = d0; req0_mod = m0;
      req1_valid = v1; req1_data = d1; req1_mod = m1;
      #1;
      g0 = v0 && (!v1 || m_last);
      g1 = v1 && (!v0 || !m_last);
      check("req0_ready", req0_ready, g0);
      check("req1_ready", req1_ready, g1);
      if (g0 || g1) begin
         mod   = g1 ? m1 : m0;
         data  = g1 ? d1 : d0;
         e.own = g1;
         e.err = (mod == 2'b11);
         e.syn = e.err ? 6'h00 : (data[5:0] ^ {4'b0000, mod});
         e.due = cyc + 1 + LAT + 1;
         q.push_back(e);
         m_last = g1;
         m_md   = e.err ? 32'h0 : data;
         m_mm   = mod;
         glog.push_back(g1 ? 1 : 0);
      end
      @(posedge clk);
      #1;
      cyc++;
      check("busy", busy, q.size() != 0);
      check("mult_data", mult_data, m_md);
      check("mult_mod", mult_mod, m_mm);
      ev0 = 1'b0; ev1 = 1'b0; ee0 = 1'b0; ee1 = 1'b0;
      if (q.size() != 0 && q[0].due == cyc) begin
         e = q.pop_front();
         if (e.own) begin
            ev1 = 1'b1; ee1 = e.err; m_hold1 = e.syn;
         end else begin
            ev0 = 1'b1; ee0 = e.err; m_hold0 = e.syn;
         end
      end
      check("rsp0_valid", rsp0_valid, ev0);
      check("rsp1_valid", rsp1_valid, ev1);
      check("rsp0_syndrome", rsp0_syndrome, m_hold0);
      check("rsp1_syndrome", rsp1_syndrome, m_hold1);
      if (ev0) check("rsp0_err", rsp0_err, ee0);
      if (ev1) check("rsp1_err", rsp1_err, ee1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00);
   endtask

   // Asynchronous reset mid-cycle; outputs must clear before any edge
   task automatic do_reset();
      #2;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rst = 1'b1;
      #1;
      model_clear();
      check("rst_ready0", req0_ready, 1'b0);
      check("rst_ready1", req1_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_rsp0_valid", rsp0_valid, 1'b0);
      check("rst_rsp1_valid", rsp1_valid, 1'b0);
      check("rst_mult_data", mult_data, 32'h0);
      check("rst_mult_mod", mult_mod, 2'b00);
      check("rst_rsp0_syn", rsp0_syndrome, 6'h00);
      check("rst_rsp1_syn", rsp1_syndrome, 6'h00);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b0;
   endtask

   initial begin
      int          first5, edge5;
      logic [5:0]  syn5;
      rst = 1'b1;
      req0_valid = 1'b0; req0_data = 32'h0; req0_mod = 2'b00;
      req1_valid = 1'b0; req1_data = 32'h0; req1_mod = 2'b00;
      model_clear();
      #1;
      check("reset_busy", busy, 1'b0);
      check("reset_mult_data", mult_data, 32'h0);
      check("reset_rsp0_valid", rsp0_valid, 1'b0);
      check("reset_rsp1_err", rsp1_err, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single request: response exactly four cycles after the handshake
      step(1'b1, 32'h0000_00B1, 2'b01, 1'b0, 32'h0, 2'b00);
      idle(3);
      check("single_rsp0_valid", rsp0_valid, 1'b1);
      check("single_syn", rsp0_syndrome, 6'h30);
      check("single_rsp1_valid", rsp1_valid, 1'b0);
      idle(2);

      // Fairness then contention: req1 alone, then both -> 0,1,0,1...
      glog.delete();
      step(1'b0, 32'h0, 2'b00, 1'b1, 32'h22, 2'b00);
      for (int i = 0; i < 6; i++) step(1'b1, 32'h11, 2'b00, 1'b1, 32'h22, 2'b00);
      check("contention_count", glog.size(), 7);
      for (int i = 0; i < 7 && i < glog.size(); i++)
         check("contention_order", glog[i], (i % 2 == 0) ? 1 : 0);
      idle(5);

      // Illegal mod on requester 1
      step(1'b0, 32'h0, 2'b00, 1'b1, 32'hFFFF_FFFF, 2'b11);
      check("illegal_mult_data", mult_data, 32'h0);
      check("illegal_mult_mod", mult_mod, 2'b11);
      idle(3);
      check("illegal_rsp1_valid", rsp1_valid, 1'b1);
      check("illegal_rsp1_syn", rsp1_syndrome, 6'h00);
      check("illegal_rsp1_err", rsp1_err, 1'b1);
      idle(2);

      // Randomized traffic against the model
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(1, 0)), $urandom(), 2'($urandom_range(3, 0)),
              1'($urandom_range(1, 0)), $urandom(), 2'($urandom_range(3, 0)));
      idle(5);

      // Reset two cycles after the last of three issues
      step(1'b1, 32'h3, 2'b00, 1'b0, 32'h0, 2'b00);
      step(1'b0, 32'h0, 2'b00, 1'b1, 32'h5, 2'b01);
      step(1'b1, 32'h7, 2'b10, 1'b0, 32'h0, 2'b00);
      idle(2);
      do_reset();
      idle(6);
      step(1'b1, 32'h9, 2'b00, 1'b1, 32'hA, 2'b00);
      check("post_reset_first_grant", glog[glog.size()-1], 0);
      idle(5);

      // LATENCY=5 instance: response seven cycles after the handshake
      do_reset();
      edge5 = cyc + 1;
      first5 = -1;
      syn5 = 6'h00;
      step(1'b1, 32'h0000_005A, 2'b10, 1'b0, 32'h0, 2'b00);
      for (int i = 0; i < 12; i++) begin
         idle(1);
         if (rsp0_valid_5 && first5 < 0) begin
            first5 = cyc;
            syn5 = rsp0_syndrome_5;
         end
      end
      check("lat5_rsp_edge", first5, edge5 + LAT5 + 1);
      check("lat5_syndrome", syn5, 6'h18);
      check("lat5_busy_idle", busy_5, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timeout");
   end

endmodule
